// File: rtl/opb_reg_sequencer.sv
// opb_reg_sequencer: round-robin sequencer that turns up to C_NUM_REQ simple
// register requests into single OPB master transfers.
// Ports:
//   OPB_Clk, OPB_Rst_n        clock, async active-low reset
//   req/req_rnw/req_addr/req_wdata/req_be   per-requester request and payload
//   done/err/rdata            completion pulse, error flag, read data
//   M_select/M_RNW/M_seqAddr/M_ABus/M_DBus/M_BE   OPB master outputs
//   Sl_DBus/Sl_xferAck/Sl_errAck/Sl_retry/Sl_toutSup   OR-ed slave responses
module opb_reg_sequencer #(
    parameter int unsigned C_NUM_REQ   = 4,
    parameter int unsigned C_TIMEOUT   = 16,
    parameter int unsigned C_MAX_RETRY = 8
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [C_NUM_REQ-1:0]    req,
    input  logic [C_NUM_REQ-1:0]    req_rnw,
    input  logic [32*C_NUM_REQ-1:0] req_addr,
    input  logic [32*C_NUM_REQ-1:0] req_wdata,
    input  logic [4*C_NUM_REQ-1:0]  req_be,
    output logic [C_NUM_REQ-1:0]    done,
    output logic                    err,
    output logic [31:0]             rdata,
    output logic                    M_select,
    output logic                    M_RNW,
    output logic                    M_seqAddr,
    output logic [0:31]             M_ABus,
    output logic [0:31]             M_DBus,
    output logic [0:3]              M_BE,
    input  logic [0:31]             Sl_DBus,
    input  logic                    Sl_xferAck,
    input  logic                    Sl_errAck,
    input  logic                    Sl_retry,
    input  logic                    Sl_toutSup
);

    localparam int unsigned GW = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
    localparam int unsigned WW = $clog2(C_TIMEOUT + 1);
    localparam int unsigned RW = $clog2(C_MAX_RETRY + 1);

    typedef enum logic [1:0] {IDLE, XFER, BACKOFF, DONE} state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         rr_q, rr_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic                  rnw_q, rnw_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic [RW-1:0]         retry_q, retry_d;
    logic                  sel_q, sel_d;
    logic [31:0]           abus_q, abus_d;
    logic [31:0]           dbus_q, dbus_d;
    logic [3:0]            mbe_q, mbe_d;
    logic                  mrnw_q, mrnw_d;
    logic [C_NUM_REQ-1:0]  done_q, done_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [GW-1:0]         pick_c;
    logic                  pick_rnw_c;
    logic [31:0]           pick_addr_c;
    logic [31:0]           pick_wdata_c;
    logic [3:0]            pick_be_c;
    logic [C_NUM_REQ-1:0]  grant_oh_c;

    // Round-robin pick: lowest pending index at/after rr_q wins, else lowest below it.
    always_comb begin
        pick_c       = '0;
        pick_rnw_c   = 1'b0;
        pick_addr_c  = '0;
        pick_wdata_c = '0;
        pick_be_c    = '0;
        for (int j = int'(C_NUM_REQ) - 1; j >= 0; j--) begin
            if (req[j] && (GW'(j) < rr_q)) pick_c = GW'(j);
        end
        for (int j = int'(C_NUM_REQ) - 1; j >= 0; j--) begin
            if (req[j] && (GW'(j) >= rr_q)) pick_c = GW'(j);
        end
        for (int j = 0; j < int'(C_NUM_REQ); j++) begin
            if (GW'(j) == pick_c) begin
                pick_rnw_c   = req_rnw[j];
                pick_addr_c  = req_addr[32*j +: 32];
                pick_wdata_c = req_wdata[32*j +: 32];
                pick_be_c    = req_be[4*j +: 4];
            end
        end
    end

    // One-hot of the current grant, used for the done pulse.
    always_comb begin
        grant_oh_c = '0;
        for (int j = 0; j < int'(C_NUM_REQ); j++) begin
            grant_oh_c[j] = (GW'(j) == grant_q);
        end
    end

    // Next-state and output logic; priority in XFER is ack > retry > timeout.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wait_d  = wait_q;
        retry_d = retry_q;
        sel_d   = sel_q;
        done_d  = '0;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick_c;
                    rnw_d   = pick_rnw_c;
                    addr_d  = pick_addr_c;
                    wdata_d = pick_wdata_c;
                    be_d    = pick_be_c;
                    retry_d = '0;
                    wait_d  = '0;
                    sel_d   = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (Sl_xferAck) begin
                    sel_d   = 1'b0;
                    err_d   = Sl_errAck;
                    rdata_d = rnw_q ? 32'(Sl_DBus) : 32'd0;
                    done_d  = grant_oh_c;
                    state_d = DONE;
                end else if (Sl_retry) begin
                    sel_d   = 1'b0;
                    retry_d = retry_q + RW'(1);
                    if (retry_d == RW'(C_MAX_RETRY)) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        done_d  = grant_oh_c;
                        state_d = DONE;
                    end else begin
                        state_d = BACKOFF;
                    end
                end else if (!Sl_toutSup && !Sl_errAck) begin
                    wait_d = wait_q + WW'(1);
                    if (wait_d == WW'(C_TIMEOUT)) begin
                        sel_d   = 1'b0;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        done_d  = grant_oh_c;
                        state_d = DONE;
                    end
                end
            end
            BACKOFF: begin
                sel_d   = 1'b1;
                wait_d  = '0;
                state_d = XFER;
            end
            DONE: begin
                rr_d    = (grant_q == GW'(C_NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are forced to zero whenever select is low to keep the OR-bus clean.
    assign abus_d = sel_d ? addr_d : '0;
    assign dbus_d = (sel_d && !rnw_d) ? wdata_d : '0;
    assign mbe_d  = sel_d ? be_d : '0;
    assign mrnw_d = sel_d & rnw_d;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wait_q  <= '0;
            retry_q <= '0;
            sel_q   <= 1'b0;
            abus_q  <= '0;
            dbus_q  <= '0;
            mbe_q   <= '0;
            mrnw_q  <= 1'b0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wait_q  <= wait_d;
            retry_q <= retry_d;
            sel_q   <= sel_d;
            abus_q  <= abus_d;
            dbus_q  <= dbus_d;
            mbe_q   <= mbe_d;
            mrnw_q  <= mrnw_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign M_select  = sel_q;
    assign M_RNW     = mrnw_q;
    assign M_seqAddr = 1'b0;
    assign M_ABus    = abus_q;
    assign M_DBus    = dbus_q;
    assign M_BE      = mbe_q;

endmodule
